// File: rtl/ds_pkg.sv
// Shared constants and types for the data-synchronizer capture buffer.
package ds_pkg;

  localparam int unsigned DS_BUS_WIDTH  = 8;
  localparam int unsigned DS_DEPTH      = 4;
  localparam int unsigned DS_DROP_CNT_W = 8;

  // FIFO occupancy classification derived from the word count.
  typedef enum logic [1:0] {
    OccEmpty,
    OccPartial,
    OccFull
  } occ_e;

  function automatic occ_e occ_of(input int unsigned cnt, input int unsigned depth);
    if (cnt == 0) begin
      return OccEmpty;
    end else if (cnt >= depth) begin
      return OccFull;
    end else begin
      return OccPartial;
    end
  endfunction

endpackage

// File: rtl/ds_capture_mem.sv
// Capture storage: DEPTH x BUS_WIDTH register array, synchronous write,
// asynchronous read. Contents are not reset; the buffer never exposes
// an entry it has not written.
module ds_capture_mem
  import ds_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = DS_BUS_WIDTH,
  parameter int unsigned DEPTH     = DS_DEPTH,
  localparam int unsigned PtrW     = $clog2(DEPTH)
) (
  input  logic                 CLK,
  input  logic                 wr_en,
  input  logic [PtrW-1:0]      wr_addr,
  input  logic [BUS_WIDTH-1:0] wr_data,
  input  logic [PtrW-1:0]      rd_addr,
  output logic [BUS_WIDTH-1:0] rd_data
);

  logic [BUS_WIDTH-1:0] mem [DEPTH];

  // Write one entry per accepted capture.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Head word read straight from the array.
  always_comb begin
    rd_data = mem[rd_addr];
  end

endmodule

// File: rtl/ds_capture_buffer.sv
// Destination-domain capture FIFO: samples unsync_bus on each enable_pulse,
// queues words and offers them through a valid/ready handshake. A push into
// a full FIFO without a same-cycle pop is dropped and flagged in the sticky
// overflow bit.
// Optional build macro DS_CAPTURE_DROP_CNT_EN adds a saturating drop_count
// output.
module ds_capture_buffer
  import ds_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = DS_BUS_WIDTH,
  parameter int unsigned DEPTH     = DS_DEPTH,
  localparam int unsigned PtrW     = $clog2(DEPTH),
  localparam int unsigned CntW     = $clog2(DEPTH) + 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  input  logic                 enable_pulse,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 out_valid,
  output logic [CntW-1:0]      fill_level,
  output logic                 overflow
`ifdef DS_CAPTURE_DROP_CNT_EN
  ,
  output logic [DS_DROP_CNT_W-1:0] drop_count
`endif
);

  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [BUS_WIDTH-1:0] head_data;
  occ_e                 occ;
  logic                 push, pop, wr_en, drop;

  // Classify occupancy and decide which requests are honoured this cycle.
  always_comb begin
    occ   = occ_of(32'(count_q), DEPTH);
    push  = enable_pulse;
    pop   = out_valid && out_ready;
    // A full FIFO still accepts a push when the head is leaving this cycle.
    wr_en = push && ((occ != OccFull) || pop);
    drop  = push && (occ == OccFull) && !pop;
  end

  // Next-state for pointers, count and sticky overflow.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q || drop;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards all queued words at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  ds_capture_mem #(
    .BUS_WIDTH (BUS_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .CLK     (CLK),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (unsync_bus),
    .rd_addr (rd_ptr_q),
    .rd_data (head_data)
  );

  // Outputs depend only on registered state; stale entries are masked.
  always_comb begin
    out_valid  = (count_q != '0);
    sync_bus   = out_valid ? head_data : '0;
    fill_level = count_q;
    overflow   = overflow_q;
  end

`ifdef DS_CAPTURE_DROP_CNT_EN
  logic [DS_DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of dropped pushes, updating alongside overflow.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DS_DROP_CNT_W'(1);
    end
  end

  // Drop counter register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Expose the counter.
  always_comb begin
    drop_count = drop_cnt_q;
  end
`endif

endmodule

// File: tb/tb_ds_capture_buffer.sv
// Directed self-checking bench for ds_capture_buffer (default parameters).
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_ds_capture_buffer;
  import ds_pkg::*;

  logic       CLK;
  logic       RST;
  logic [7:0] unsync_bus;
  logic       enable_pulse;
  logic       out_ready;
  logic [7:0] sync_bus;
  logic       out_valid;
  logic [2:0] fill_level;
  logic       overflow;
`ifdef DS_CAPTURE_DROP_CNT_EN
  logic [7:0] drop_count;
`endif

  int n_checks;
  int n_errors;

  ds_capture_buffer #(
    .BUS_WIDTH (8),
    .DEPTH     (4)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .unsync_bus   (unsync_bus),
    .enable_pulse (enable_pulse),
    .out_ready    (out_ready),
    .sync_bus     (sync_bus),
    .out_valid    (out_valid),
    .fill_level   (fill_level),
    .overflow     (overflow)
`ifdef DS_CAPTURE_DROP_CNT_EN
    ,
    .drop_count   (drop_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_words(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      unsync_bus   = 8'(first + i);
      enable_pulse = 1'b1;
      step();
    end
    enable_pulse = 1'b0;
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    RST          = 1'b1;
    unsync_bus   = '0;
    enable_pulse = 1'b0;
    out_ready    = 1'b0;
    step();
    step();
    RST = 1'b0;

    // Reset state
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_fill", 32'(fill_level), 32'd0);
    check("rst_sync", 32'(sync_bus), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // Single capture and pop
    unsync_bus   = 8'hA5;
    enable_pulse = 1'b1;
    step();
    enable_pulse = 1'b0;
    check("single_sync", 32'(sync_bus), 32'hA5);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_fill", 32'(fill_level), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("single_pop_valid", 32'(out_valid), 32'd0);
    check("single_pop_sync", 32'(sync_bus), 32'd0);
    check("single_pop_fill", 32'(fill_level), 32'd0);

    // Fill and overflow: fifth word is dropped
    push_words(1, 4);
    check("fill4_fill", 32'(fill_level), 32'd4);
    check("fill4_ovf", 32'(overflow), 32'd0);
    push_words(5, 1);
    check("ovf_fill", 32'(fill_level), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
`ifdef DS_CAPTURE_DROP_CNT_EN
    check("ovf_drop_cnt", 32'(drop_count), 32'd1);
`endif
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ovf_pop%0d", i), 32'(sync_bus), 32'(i));
      step();
    end
    out_ready = 1'b0;
    check("ovf_drain_valid", 32'(out_valid), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-stream with 3 words queued
    push_words(8'h30, 3);
    check("mid_fill", 32'(fill_level), 32'd3);
    pulse_reset();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_fill", 32'(fill_level), 32'd0);
    check("mid_rst_sync", 32'(sync_bus), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);

    // Full with simultaneous push and pop
    push_words(8'h10, 4);
    check("fullpp_fill", 32'(fill_level), 32'd4);
    check("fullpp_head", 32'(sync_bus), 32'h10);
    unsync_bus   = 8'h14;
    enable_pulse = 1'b1;
    out_ready    = 1'b1;
    step();
    enable_pulse = 1'b0;
    check("fullpp_ovf", 32'(overflow), 32'd0);
    check("fullpp_fill_after", 32'(fill_level), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fullpp_pop%0d", i), 32'(sync_bus), 32'(8'h11 + i));
      step();
    end
    out_ready = 1'b0;
    check("fullpp_empty", 32'(out_valid), 32'd0);

    // Wrap-around: back-to-back captures drained every cycle
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      unsync_bus   = 8'(i);
      enable_pulse = 1'b1;
      step();
      check($sformatf("wrap_data%0d", i), 32'(sync_bus), 32'(i));
      check($sformatf("wrap_fill%0d", i), 32'(fill_level), 32'd1);
    end
    enable_pulse = 1'b0;
    step();
    out_ready = 1'b0;
    check("wrap_empty", 32'(out_valid), 32'd0);
    check("wrap_ovf", 32'(overflow), 32'd0);

`ifdef DS_CAPTURE_DROP_CNT_EN
    // Saturation of the drop counter
    push_words(0, 4);
    push_words(0, 300);
    check("sat_drop_cnt", 32'(drop_count), 32'd255);
    push_words(0, 2);
    check("sat_drop_hold", 32'(drop_count), 32'd255);
    check("sat_fill", 32'(fill_level), 32'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
